a_rr_arbiter: RTL and testbench

- Clocked round-robin arbiter that shares one bundled-data downstream stage (for example an `a_and` / `combine` pipeline) between M asynchronous requester channels.
- Each requester channel is 4-phase, return-to-zero, bundled-data: `r`/`a`/`d`.
- The block synchronises incoming requests and acks, then grants one channel at a time.
- For the granted channel it registers the data, inserts a programmable bundling setup delay before raising `r_o`, and completes the full 4-phase cycle on both sides before re-arbitrating.

---
 rtl/a_arb_pkg.sv | 38 +++
 rtl/a_sync.sv | 32 +++
 rtl/a_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_a_rr_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/a_arb_pkg.sv
// Shared types and helpers for the asynchronous-channel round-robin arbiter.
package a_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_ACK,
        WAIT_RTZ
    } arb_state_t;

    // Upper bound on the number of requester channels rr_pick can scan.
    localparam int unsigned MAX_CH = 32;

    // First active request found searching ptr+1, ptr+2, ... modulo m.
    // Returns ptr when nothing is active; callers gate on |req.
    function automatic int unsigned rr_pick(
        input logic [MAX_CH-1:0] req,
        input int unsigned       ptr,
        input int unsigned       m
    );
        int unsigned pick;
        logic        found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= m; i++) begin
            int unsigned       idx;
            logic [MAX_CH-1:0] sh;
            idx = (ptr + i) % m;
            sh  = req >> idx;
            if (!found && sh[0]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/a_sync.sv
// Multi-flop level synchroniser with a synchronous reset to a chosen idle level.
module a_sync
    import a_arb_pkg::*;
#(
    parameter int unsigned W       = 1,
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= {W{RST_VAL}};
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/a_rr_arbiter.sv
// Round-robin arbiter sharing one bundled-data downstream stage between M
// asynchronous 4-phase requester channels.
module a_rr_arbiter
    import a_arb_pkg::*;
#(
    parameter logic        Rpol = 1'b0,
    parameter int unsigned N    = 32'd1,
    parameter int unsigned M    = 32'd2,
    parameter int unsigned T    = 32'd2,
    parameter int unsigned SYNC = 32'd2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   r_i,
    output logic [M-1:0]   a_i,
    input  logic [M*N-1:0] d_i,
    output logic           r_o,
    input  logic           a_o,
    output logic [N-1:0]   d_o,
    output logic [M-1:0]   gnt_o
);

    localparam int unsigned PW = $clog2(M);
    localparam int unsigned CW = $clog2(T + 1);

    arb_state_t        state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     sel;
    logic [CW-1:0]     cnt;
    logic [M-1:0]      rq_s;
    logic              ao_s;
    logic [M-1:0]      rq_act;
    logic              ao_act;
    logic [MAX_CH-1:0] req_ext;
    logic [PW-1:0]     pick;
    logic [M-1:0]      pick_onehot;
    logic [N-1:0]      pick_data;

    a_sync #(.W(M), .DEPTH(SYNC), .RST_VAL(Rpol)) u_sync_req (
        .clk (clk),
        .rst (rst),
        .d   (r_i),
        .q   (rq_s)
    );

    a_sync #(.W(1), .DEPTH(SYNC), .RST_VAL(Rpol)) u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d   (a_o),
        .q   (ao_s)
    );

    // Normalise polarity once so all decisions below test for '1 = active.
    assign rq_act = rq_s ^ {M{Rpol}};
    assign ao_act = ao_s ^ Rpol;

    always_comb begin
        req_ext         = '0;
        req_ext[M-1:0]  = rq_act;
        pick            = PW'(rr_pick(req_ext, 32'(ptr), M));
    end

    always_comb begin
        pick_onehot = '0;
        pick_data   = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (pick == PW'(i)) begin
                pick_onehot[i] = 1'b1;
                pick_data      = d_i[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= PW'(M - 1);
            sel   <= '0;
            cnt   <= '0;
            r_o   <= Rpol;
            a_i   <= {M{Rpol}};
            d_o   <= '0;
            gnt_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|rq_act) begin
                        sel   <= pick;
                        gnt_o <= pick_onehot;
                        d_o   <= pick_data;
                        cnt   <= CW'(T - 1);
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    // cnt starts at T-1 so r_o rises exactly T edges after d_o.
                    if (cnt == '0) begin
                        r_o   <= ~Rpol;
                        state <= WAIT_ACK;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WAIT_ACK: begin
                    if (ao_act) begin
                        a_i[sel] <= ~Rpol;
                        r_o      <= Rpol;
                        state    <= WAIT_RTZ;
                    end
                end
                WAIT_RTZ: begin
                    if (!rq_act[sel] && !ao_act) begin
                        a_i[sel] <= Rpol;
                        ptr      <= sel;
                        gnt_o    <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a_rr_arbiter.sv
// Randomised scoreboard bench for a_rr_arbiter with inverted polarity and M=3.
module tb_a_rr_arbiter;

    localparam int unsigned M    = 3;
    localparam int unsigned N    = 8;
    localparam int unsigned T    = 4;
    localparam int unsigned SYNC = 2;
    localparam logic        RPOL = 1'b1;
    localparam logic        ACT  = ~RPOL;
    localparam logic        IDL  = RPOL;

    logic           clk = 1'b0;
    logic           rst;
    logic [M-1:0]   r_i;
    logic [M-1:0]   a_i;
    logic [M*N-1:0] d_i;
    logic           r_o;
    logic           a_o;
    logic [N-1:0]   d_o;
    logic [M-1:0]   gnt_o;

    a_rr_arbiter #(.Rpol(RPOL), .N(N), .M(M), .T(T), .SYNC(SYNC)) dut (
        .clk   (clk),
        .rst   (rst),
        .r_i   (r_i),
        .a_i   (a_i),
        .d_i   (d_i),
        .r_o   (r_o),
        .a_o   (a_o),
        .d_o   (d_o),
        .gnt_o (gnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned  ch;
        logic [N-1:0] data;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          ph[M];
    int          cd[M];
    int          rph, rcd;
    bit          ack_real, resp_en, pulse_en, pulse_clr;
    logic [M-1:0] sg;
    int unsigned mptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT raises r_o.
    initial begin
        logic [M-1:0] pg, pa;
        logic         pr;
        logic [N-1:0] pd;
        int           since;
        exp_t         e;
        pg = '0; pa = {M{IDL}}; pr = IDL; pd = '0; since = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (gnt_o != '0 && pg == '0) since = 0;
                else begin
                    since++;
                    check("d_o_hold", 64'(d_o), 64'(pd));
                end
                if (r_o == ACT && pr == IDL) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req: got r_o active expected no request");
                    end else begin
                        e = sb.pop_front();
                        check("grant", 64'(gnt_o), 64'(M'(1) << e.ch));
                        check("data", 64'(d_o), 64'(e.data));
                        check("setup_delay", 64'(since), 64'(T));
                    end
                end
                if (a_i != {M{IDL}}) begin
                    check("ack_onehot", 64'($countones(a_i ^ {M{IDL}})), 64'(1));
                    check("ack_owner", 64'(a_i ^ {M{IDL}}), 64'(gnt_o));
                    if (pa == {M{IDL}}) check("ack_after_real_ack", 64'(ack_real), 64'(1));
                end
            end
            pg = gnt_o; pr = r_o; pa = a_i; pd = d_o;
        end
    end

    // One clock of behavioural requesters and downstream responder.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < M; k++) begin
            if (ph[k] == 1 && a_i[k] == ACT) begin
                if (cd[k] == 0) begin
                    r_i[k] = IDL;
                    ph[k]  = 2;
                end else cd[k]--;
            end else if (ph[k] == 2 && a_i[k] == IDL) begin
                ph[k] = 0;
            end
        end
        if (pulse_clr) begin
            a_o = IDL;
            pulse_clr = 1'b0;
        end else if (pulse_en && rph == 0 && gnt_o != '0 && sg == '0) begin
            a_o = ACT;
            pulse_clr = 1'b1;
        end
        if (resp_en) begin
            case (rph)
                0: if (r_o == ACT) begin rcd = int'($urandom % 3); rph = 1; end
                1: if (rcd == 0) begin a_o = ACT; ack_real = 1'b1; rph = 2; end else rcd--;
                2: if (r_o == IDL) begin rcd = int'($urandom % 3); rph = 3; end
                default: if (rcd == 0) begin a_o = IDL; ack_real = 1'b0; rph = 0; end else rcd--;
            endcase
        end
        sg = gnt_o;
    endtask

    // Reference model: pending channels are served cyclically from ptr+1.
    task automatic start_round(input logic [M-1:0] mask);
        int unsigned ch, last;
        logic [N-1:0] dat;
        last = mptr;
        for (int unsigned i = 1; i <= M; i++) begin
            ch = (mptr + i) % M;
            if (mask[ch]) begin
                dat = N'($urandom);
                d_i[ch*N +: N] = dat;
                r_i[ch] = ACT;
                ph[ch]  = 1;
                cd[ch]  = int'($urandom % 3);
                sb.push_back('{ch, dat});
                last = ch;
            end
        end
        mptr = last;
    endtask

    task automatic wait_round();
        int  n, lat;
        bit  done;
        n = 0; lat = -1; done = 1'b0;
        while (n < 400 && !done) begin
            step();
            n++;
            if (lat < 0 && gnt_o != '0) lat = n;
            done = (ph[0] == 0 && ph[1] == 0 && ph[2] == 0 && rph == 0 &&
                    gnt_o == '0 && a_o == IDL && !pulse_clr);
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL round_timeout: got busy after %0d cycles expected idle", n);
        end
        check("grant_latency", 64'(lat), 64'(SYNC + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; r_i = {M{IDL}}; a_o = IDL; d_i = '0;
        for (int k = 0; k < M; k++) begin ph[k] = 0; cd[k] = 0; end
        rph = 0; rcd = 0; ack_real = 1'b0; resp_en = 1'b1; pulse_en = 1'b0;
        pulse_clr = 1'b0; sg = '0; mptr = M - 1;
        repeat (3) @(negedge clk);
        check("rst_r_o", 64'(r_o), 64'(IDL));
        check("rst_a_i", 64'(a_i), 64'({M{IDL}}));
        check("rst_d_o", 64'(d_o), 64'(0));
        check("rst_gnt", 64'(gnt_o), 64'(0));
        rst = 1'b0;
        repeat (2) step();

        start_round(3'b001); wait_round();
        for (int r = 0; r < 3; r++) begin start_round('1); wait_round(); step(); end
        start_round(3'b110); wait_round();

        for (int r = 0; r < 40; r++) begin
            pulse_en = bit'($urandom % 2);
            start_round(M'($urandom_range(1, (1 << M) - 1)));
            wait_round();
            repeat ($urandom % 4) step();
        end
        pulse_en = 1'b0;

        // Reset while waiting for downstream ack; pointer must return to M-1.
        resp_en = 1'b0;
        start_round(3'b010);
        n = 0;
        while (n < 50 && r_o != ACT) begin step(); n++; end
        check("reach_wait_ack", 64'(r_o), 64'(ACT));
        repeat (2) step();
        rst = 1'b1; r_i = {M{IDL}}; a_o = IDL;
        for (int k = 0; k < M; k++) ph[k] = 0;
        step();
        check("mid_rst_r_o", 64'(r_o), 64'(IDL));
        check("mid_rst_a_i", 64'(a_i), 64'({M{IDL}}));
        check("mid_rst_gnt", 64'(gnt_o), 64'(0));
        check("mid_rst_d_o", 64'(d_o), 64'(0));
        rst = 1'b0;
        mptr = M - 1;
        resp_en = 1'b1;
        repeat (2) step();
        start_round('1); wait_round();

        repeat (3) step();
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
